// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, HALT word, FSM states, ALU codes.
// Used by the register file, the ALU and the control sequencer.
package cpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_NOP = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam logic [7:0] INSTR_HALT = 8'hBF;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_NONE = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  function automatic logic [7:0] sext6(
    input logic [5:0] imm
  );
    return {{2{imm[5]}}, imm};
  endfunction

  function automatic logic isAluOp(
    input logic [1:0] op
  );
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter with increment and relative jump (modulo 256).
// Ports: clk, reset, inc, jmp, imm6 in; pc out (registered).
module pc_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       jmp,
  input  logic [5:0] imm6,
  output logic [7:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= 8'h00;
    end else begin
      unique case (1'b1)
        jmp:     pc <= pc + sext6(imm6);
        inc:     pc <= pc + 8'd1;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM: fetch/decode/exec/writeback/halt, owns IR.
// Ports: clk, reset, run, instr in; PC, rs, rt, rd, RegWrite, ALUop, state, halted out.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] instr,
  output logic [7:0] PC,
  output logic [1:0] rs,
  output logic [1:0] rt,
  output logic [1:0] rd,
  output logic       RegWrite,
  output logic [1:0] ALUop,
  output logic [2:0] state,
  output logic       halted
);

  state_t     cur;
  logic [7:0] ir;
  logic       pcInc;
  logic       pcJmp;

  assign rs    = ir[5:4];
  assign rt    = ir[3:2];
  assign rd    = ir[1:0];
  assign state = cur;

  assign pcInc = (cur == S_FETCH) && run;
  assign pcJmp = (cur == S_EXEC) && (ir[7:6] == OP_JMP);

  pc_unit uPc (
    .clk   (clk),
    .reset (reset),
    .inc   (pcInc),
    .jmp   (pcJmp),
    .imm6  (ir[5:0]),
    .pc    (PC)
  );

  // Outputs are registered alongside the state so they
  // always reflect the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= S_FETCH;
      ir       <= 8'h00;
      RegWrite <= 1'b0;
      ALUop    <= ALU_NONE;
      halted   <= 1'b0;
    end else begin
      unique case (cur)
        S_FETCH: begin
          RegWrite <= 1'b0;
          if (run) begin
            ir    <= instr;
            cur   <= S_DECODE;
            ALUop <= isAluOp(instr[7:6]) ? instr[7:6] : ALU_NONE;
          end
        end
        S_DECODE: begin
          if (ir == INSTR_HALT) begin
            cur    <= S_HALT;
            halted <= 1'b1;
            ALUop  <= ALU_NONE;
          end else begin
            cur <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (isAluOp(ir[7:6])) begin
            cur      <= S_WB;
            RegWrite <= 1'b1;
          end else begin
            cur   <= S_FETCH;
            ALUop <= ALU_NONE;
          end
        end
        S_WB: begin
          cur      <= S_FETCH;
          RegWrite <= 1'b0;
          ALUop    <= ALU_NONE;
        end
        S_HALT: begin
          RegWrite <= 1'b0;
          halted   <= 1'b1;
        end
        default: begin
          cur      <= S_FETCH;
          RegWrite <= 1'b0;
          ALUop    <= ALU_NONE;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
// Drives instr directly; expected values are hand-computed.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] instr;
  logic [7:0] PC;
  logic [1:0] rs;
  logic [1:0] rt;
  logic [1:0] rd;
  logic       RegWrite;
  logic [1:0] ALUop;
  logic [2:0] state;
  logic       halted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .instr    (instr),
    .PC       (PC),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .RegWrite (RegWrite),
    .ALUop    (ALUop),
    .state    (state),
    .halted   (halted)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic nopN(input int n);
    for (int i = 0; i < n; i++) begin
      instr = 8'h80;
      step();
      step();
      step();
    end
  endtask

  logic sawWrite;

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    instr = 8'h00;
    step();
    reset = 1'b0;
    chk("rst_state", 32'(state), 0);
    chk("rst_pc", 32'(PC), 0);
    chk("rst_regs", 32'({rs, rt, rd}), 0);
    chk("rst_alu", 32'(ALUop), 3);
    chk("rst_rw", 32'(RegWrite), 0);
    chk("rst_halt", 32'(halted), 0);

    // ADD r3 = r1 + r2
    run   = 1'b1;
    instr = 8'h1B;
    step();
    chk("add_s1", 32'(state), 1);
    chk("add_pc", 32'(PC), 1);
    chk("add_rs", 32'(rs), 1);
    chk("add_rt", 32'(rt), 2);
    chk("add_alu1", 32'(ALUop), 0);
    chk("add_rw1", 32'(RegWrite), 0);
    step();
    chk("add_s2", 32'(state), 2);
    chk("add_rw2", 32'(RegWrite), 0);
    chk("add_alu2", 32'(ALUop), 0);
    step();
    chk("add_s3", 32'(state), 3);
    chk("add_rw3", 32'(RegWrite), 1);
    chk("add_rd", 32'(rd), 3);
    chk("add_alu3", 32'(ALUop), 0);
    step();
    chk("add_s4", 32'(state), 0);
    chk("add_rw4", 32'(RegWrite), 0);
    chk("add_alu4", 32'(ALUop), 3);
    chk("add_pc4", 32'(PC), 1);

    // JMP -2 from PC=5
    doReset();
    nopN(5);
    chk("nop5_pc", 32'(PC), 5);
    instr = 8'hFE;
    step();
    chk("jb_pc1", 32'(PC), 6);
    step();
    chk("jb_exec", 32'(state), 2);
    step();
    chk("jb_state", 32'(state), 0);
    chk("jb_pc", 32'(PC), 4);

    // JMP -17 from 0 lands at F0, then JMP +31 wraps to 10
    doReset();
    instr = 8'hEF;
    step();
    step();
    step();
    chk("jm17_pc", 32'(PC), 8'hF0);
    instr = 8'hDF;
    step();
    step();
    step();
    chk("jp31_pc", 32'(PC), 8'h10);

    // run low holds FETCH
    doReset();
    run = 1'b0;
    instr = 8'h80;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_state", 32'(state), 0);
      chk("hold_pc", 32'(PC), 0);
    end
    run = 1'b1;
    step();
    chk("go_state", 32'(state), 1);
    chk("go_pc", 32'(PC), 1);
    step();
    step();

    // HALT
    doReset();
    instr = 8'hBF;
    step();
    chk("h_s1", 32'(state), 1);
    chk("h_halt1", 32'(halted), 0);
    step();
    chk("h_state", 32'(state), 4);
    chk("h_halted", 32'(halted), 1);
    chk("h_alu", 32'(ALUop), 3);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("h_pc", 32'(PC), 1);
      chk("h_st", 32'(state), 4);
      chk("h_rw", 32'(RegWrite), 0);
    end
    doReset();
    chk("h_rst_pc", 32'(PC), 0);
    chk("h_rst_state", 32'(state), 0);
    chk("h_rst_halt", 32'(halted), 0);

    // reset during WB of SUB r0 = r2 - r1
    instr = 8'h64;
    step();
    step();
    step();
    chk("sub_wb", 32'(state), 3);
    chk("sub_rw", 32'(RegWrite), 1);
    chk("sub_alu", 32'(ALUop), 1);
    chk("sub_regs", 32'({rs, rt, rd}), 32'b100100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("sub_rst_rw", 32'(RegWrite), 0);
    chk("sub_rst_st", 32'(state), 0);
    chk("sub_rst_pc", 32'(PC), 0);
    chk("sub_rst_alu", 32'(ALUop), 3);

    // 256 NOPs wrap PC to 00
    sawWrite = 1'b0;
    instr = 8'h80;
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 3; k++) begin
        step();
        if (RegWrite) sawWrite = 1'b1;
      end
      if (i == 254) chk("nop_pc_ff", 32'(PC), 8'hFF);
    end
    chk("nop_wrap_pc", 32'(PC), 0);
    chk("nop_state", 32'(state), 0);
    chk("nop_no_rw", 32'(sawWrite), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have the port clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port reset  input  1  synchronous, active-high reset sampled on rising clk.
REQ-003 The block SHALL have the port run  input  1  allows leaving FETCH when high.
REQ-004 The block SHALL have the port instr  input  8  instruction word from instruction memory, addressed combinationally by PC.
REQ-005 The block SHALL have the port PC  output  8  program counter, registered.
REQ-006 The block SHALL have the ports rs, rt  output  2 each  register-file read selects, taken from IR[5:4] and IR[3:2].
REQ-007 The block SHALL have the port rd  output  2  register-file write select, taken from IR[1:0].
REQ-008 The block SHALL have the port RegWrite  output  1  register-file write enable, high exactly one cycle per ADD/SUB.
REQ-009 The block SHALL have the port ALUop  output  2  00 add, 01 sub, 11 pass/none.
REQ-010 The block SHALL have the port state  output  3  current FSM state (debug).
REQ-011 The block SHALL have the port halted  output  1  high while in HALT.

Function
REQ-012 Instruction format SHALL be op=IR[7:6], rs=IR[5:4], rt=IR[3:2], rd=IR[1:0]; imm6=IR[5:0].
REQ-013 Opcodes SHALL be 00 ADD (rd<=rs+rt), 01 SUB (rd<=rs-rt), 10 NOP, 11 JMP (PC<=PC+sext(imm6)); 8'b10111111 SHALL be HALT.
REQ-014 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, WB=3, HALT=4.
REQ-015 FETCH: if run=1, IR<=instr, PC<=PC+1, next DECODE; if run=0, hold FETCH with PC and IR unchanged.
REQ-016 DECODE: rs/rt driven from IR; next HALT if IR==8'hBF, else EXEC.
REQ-017 EXEC: ADD/SUB next WB; NOP next FETCH; JMP sets PC<=PC+sext(imm6), next FETCH.
REQ-018 JMP offset SHALL be relative to the already-incremented PC; the sum SHALL be modulo 256.
REQ-019 WB: RegWrite=1, rd=IR[1:0], ALUop held; next FETCH. RegWrite SHALL be 0 in every other state.
REQ-020 ADD/SUB SHALL take 4 cycles; NOP and JMP 3 cycles; HALT entered 2 cycles after fetch.
REQ-021 ALUop SHALL equal op for ADD/SUB in DECODE, EXEC and WB, and 11 otherwise.
REQ-022 PC increment from 8'hFF SHALL wrap to 8'h00.
REQ-023 HALT SHALL be absorbing (halted=1, RegWrite=0, PC frozen) until reset; run is ignored there.
REQ-024 rs/rt/rd SHALL be pure functions of IR, so they are stable through DECODE, EXEC and WB.

Reset
REQ-025 When reset=1 at a rising edge: state<=FETCH, PC<=8'h00, IR<=8'h00, and halted=0 after that edge.
REQ-026 Reset SHALL take priority over all transitions, including in WB and HALT; no register-file write SHALL be issued in the cycle after a reset edge.
REQ-027 Outputs after reset SHALL be rs=rt=rd=0, ALUop=11, RegWrite=0, state=0.

Structure
REQ-028 The opcode constants, the HALT encoding, the state encodings and ALUop codes SHALL live in the shared package cpu_pkg used by the register file, ALU and this block.
REQ-029 The PC register and its adder (increment and relative jump) SHALL be one sub-module, pc_unit; the FSM and IR SHALL stay in control_sequencer.

Verification
REQ-030 The bench SHALL cover: reset, run=1, instr=8'h1B (ADD rs=1,rt=2,rd=3) -> states 0,1,2,3, with RegWrite=1 only in cycle 4, rd=3, ALUop=00, PC=8'h01.
REQ-031 The bench SHALL cover: PC=8'h05, instr=8'hFE (JMP -2) -> after EXEC PC=8'h04; and JMP +31 from PC=8'hF0 -> PC=8'h10 (wrap).
REQ-032 The bench SHALL cover: run=0 for 5 cycles in FETCH -> state=0 and PC unchanged; then run=1 -> fetch proceeds next edge.
REQ-033 The bench SHALL cover: instr=8'hBF -> HALT after 2 cycles, halted=1, PC frozen for 10 cycles with run=1; then reset -> PC=0, state=0.
REQ-034 The bench SHALL cover: reset asserted during WB of a SUB (8'h64) -> RegWrite=0 on the following cycle, state=0, PC=8'h00.
REQ-035 The bench SHALL cover: 256 NOPs (8'h80) from PC=0 -> PC wraps to 8'h00, with RegWrite never asserted.
